// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types and constants.
// State encoding for the hazard controller and the NOP word.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } ctrl_state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector between the EX and ID stages.
// Ports: EX rd/load flag, ID rs1/rs2 + use flags -> lu_o.
module hazard_detect #(
  parameter int RegAddrW = 5
) (
  input  logic [RegAddrW-1:0] rd_ex,
  input  logic                ld_ex,
  input  logic [RegAddrW-1:0] rs1_id,
  input  logic [RegAddrW-1:0] rs2_id,
  input  logic                rs1_used_id,
  input  logic                rs2_used_id,
  output logic                lu_o
);

  logic rd_live;
  logic hit1;
  logic hit2;

  // x0 never carries a value, so a load to it can't create a hazard.
  assign rd_live = ld_ex & (rd_ex != '0);
  assign hit1    = rs1_used_id & (rs1_id == rd_ex);
  assign hit2    = rs2_used_id & (rs2_id == rd_ex);
  assign lu_o    = rd_live & (hit1 | hit2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hold/bubble controller for the 5-stage pipe.
// In: EX/ID hazard fields, mispredict, MEM handshake; out: stage controls.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RegAddrW      = 5,
  parameter int TimeoutCycles = 64,
  parameter int CntWidth      = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [RegAddrW-1:0] rd_EX,
  input  logic                ld_EX,
  input  logic [RegAddrW-1:0] rs1_ID,
  input  logic [RegAddrW-1:0] rs2_ID,
  input  logic                rs1_used_ID,
  input  logic                rs2_used_ID,
  input  logic                mispred_EX,
  input  logic                mem_op_MEM,
  input  logic                dmem_ready_i,
  output logic                dmem_req_o,
  output logic                stall_IF_o,
  output logic                hold_IF_ID_o,
  output logic                flush_IF_ID_o,
  output logic                flush_ID_EX_o,
  output logic                hold_EX_MEM_o,
  output logic                bubble_MEM_WB_o,
  output logic                err_o,
  output logic [CntWidth-1:0] stall_cnt_o
);

  localparam int WaitW = $clog2(TimeoutCycles) + 1;
  localparam logic [WaitW-1:0] WaitLast =
    WaitW'(TimeoutCycles - 1);

  ctrl_state_e       state_q;
  logic [WaitW-1:0]  wait_q;
  logic              lu;
  logic              mem_stall;
  logic              freeze;
  logic              stall_evt;
  logic              sel_fz;
  logic              sel_mis;
  logic              sel_lu;

  hazard_detect #(
    .RegAddrW(RegAddrW)
  ) u_hd (
    .rd_ex       (rd_EX),
    .ld_ex       (ld_EX),
    .rs1_id      (rs1_ID),
    .rs2_id      (rs2_ID),
    .rs1_used_id (rs1_used_ID),
    .rs2_used_id (rs2_used_ID),
    .lu_o        (lu)
  );

  assign mem_stall = mem_op_MEM & ~dmem_ready_i;
  assign freeze    = (state_q == ERR) | mem_stall;
  assign stall_evt = freeze | (lu & ~mispred_EX);

  // One-hot priority selects: freeze > mispredict > load-use.
  assign sel_fz  = freeze;
  assign sel_mis = ~freeze & mispred_EX;
  assign sel_lu  = ~freeze & ~mispred_EX & lu;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      wait_q      <= '0;
      err_o       <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mem_stall) begin
            state_q <= MEM_WAIT;
            wait_q  <= '0;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready_i) begin
            state_q <= RUN;
          end else if (wait_q == WaitLast) begin
            state_q <= ERR;
            err_o   <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ERR: begin
          state_q <= ERR;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
      if (stall_evt && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
    end
  end

  // Gated by reset so nothing leaks out while the block is held.
  always_comb begin
    dmem_req_o      = 1'b0;
    stall_IF_o      = 1'b0;
    hold_IF_ID_o    = 1'b0;
    flush_IF_ID_o   = 1'b0;
    flush_ID_EX_o   = 1'b0;
    hold_EX_MEM_o   = 1'b0;
    bubble_MEM_WB_o = 1'b0;
    if (!rst_i) begin
      dmem_req_o = mem_op_MEM & (state_q != ERR);
      unique case (1'b1)
        sel_fz: begin
          stall_IF_o      = 1'b1;
          hold_IF_ID_o    = 1'b1;
          hold_EX_MEM_o   = 1'b1;
          bubble_MEM_WB_o = 1'b1;
        end
        sel_mis: begin
          flush_IF_ID_o = 1'b1;
          flush_ID_EX_o = 1'b1;
        end
        sel_lu: begin
          stall_IF_o    = 1'b1;
          hold_IF_ID_o  = 1'b1;
          flush_ID_EX_o = 1'b1;
        end
        default: begin
          stall_IF_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed cases then random vs model.
// Control vector order: req,stallIF,holdIFID,flIFID,flIDEX,holdEXMEM,bub.
module tb_pipe_hazard_ctrl;

  localparam int AW   = 5;
  localparam int TO   = 4;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b0110100;
  localparam logic [6:0] C_MIS  = 7'b0001100;
  localparam logic [6:0] C_FZ   = 7'b1110011;
  localparam logic [6:0] C_EFZ  = 7'b0110011;
  localparam logic [6:0] C_REQ  = 7'b1000000;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rd, rs1, rs2;
  logic          ld, u1, u2, mis, mop, rdy;
  logic          req, st_if, h_ifid, f_ifid, f_idex, h_exmem, bub, err;
  logic [CW-1:0] cnt;
  logic [6:0]    ctl;

  int n_chk = 0;
  int n_err = 0;

  bit m_err;
  bit m_pend;
  int m_waited;
  int m_cnt;

  always #5 clk = ~clk;

  assign ctl = {req, st_if, h_ifid, f_ifid, f_idex, h_exmem, bub};

  pipe_hazard_ctrl #(
    .RegAddrW(AW), .TimeoutCycles(TO), .CntWidth(CW)
  ) u_dut (
    .clk_i(clk), .rst_i(rst),
    .rd_EX(rd), .ld_EX(ld),
    .rs1_ID(rs1), .rs2_ID(rs2),
    .rs1_used_ID(u1), .rs2_used_ID(u2),
    .mispred_EX(mis), .mem_op_MEM(mop),
    .dmem_ready_i(rdy), .dmem_req_o(req),
    .stall_IF_o(st_if), .hold_IF_ID_o(h_ifid),
    .flush_IF_ID_o(f_ifid), .flush_ID_EX_o(f_idex),
    .hold_EX_MEM_o(h_exmem), .bubble_MEM_WB_o(bub),
    .err_o(err), .stall_cnt_o(cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit lu_ref();
    if (!ld || rd == 0) return 0;
    return (u1 && rs1 == rd) || (u2 && rs2 == rd);
  endfunction

  function automatic logic [6:0] model_ctl();
    bit fz;
    logic [6:0] v;
    if (rst) return C_NONE;
    fz = m_err || (mop && !rdy);
    if (fz)            v = C_EFZ;
    else if (mis)      v = C_MIS;
    else if (lu_ref()) v = C_LU;
    else               v = C_NONE;
    v[6] = mop && !m_err;
    return v;
  endfunction

  task automatic model_clear();
    m_err = 0; m_pend = 0; m_waited = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit fz;
    fz = m_err || (mop && !rdy);
    if ((fz || (lu_ref() && !mis)) && m_cnt < CMAX) m_cnt++;
    if (!m_err) begin
      if (!m_pend) begin
        if (mop && !rdy) begin
          m_pend = 1; m_waited = 0;
        end
      end else if (rdy) begin
        m_pend = 0;
      end else if (m_waited == TO - 1) begin
        m_err = 1;
      end else begin
        m_waited++;
      end
    end
  endtask

  task automatic clr_in();
    rd = 0; rs1 = 0; rs2 = 0; ld = 0; u1 = 0; u2 = 0;
    mis = 0; mop = 0; rdy = 1;
  endtask

  // One clock: combinational check at negedge, state after posedge.
  task automatic step(input string tag, input bit has_exp,
                      input logic [6:0] exp);
    @(negedge clk);
    chk({tag, "_ctl"}, 32'(ctl), 32'(model_ctl()));
    if (has_exp) chk({tag, "_dir"}, 32'(ctl), 32'(exp));
    model_step();
    @(posedge clk); #1;
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    chk({tag, "_cnt"}, 32'(cnt), 32'(m_cnt));
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1;
    model_clear();
    @(posedge clk); #1;
    chk("rst_ctl", 32'(ctl), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cnt", 32'(cnt), 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic mid_reset(input string tag);
    #2 rst = 1;
    #1;
    model_clear();
    chk({tag, "_ctl"}, 32'(ctl), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_cnt"}, 32'(cnt), 0);
    @(negedge clk);
    rst = 0;
    clr_in();
    @(posedge clk); #1;
  endtask

  initial begin
    clr_in();
    rst = 1;
    model_clear();
    #12;
    chk("por_ctl", 32'(ctl), 0);
    chk("por_err", 32'(err), 0);
    chk("por_cnt", 32'(cnt), 0);
    do_reset();

    step("idle", 1, C_NONE);

    ld = 1; rd = 5; rs1 = 5; u1 = 1;
    step("lu", 1, C_LU);
    clr_in();
    step("lu_end", 1, C_NONE);
    chk("lu_cnt", 32'(cnt), 1);

    ld = 1; rd = 0; rs1 = 0; u1 = 1;
    step("x0", 1, C_NONE);
    rd = 7; rs2 = 7; u2 = 0;
    step("unused", 1, C_NONE);
    chk("x0_cnt", 32'(cnt), 1);

    do_reset();
    mop = 1; rdy = 0;
    for (int i = 0; i < 3; i++) step("wait", 1, C_FZ);
    rdy = 1;
    step("rel", 1, C_REQ);
    mop = 0;
    step("rel_idle", 1, C_NONE);
    chk("wait_cnt", 32'(cnt), 3);
    mop = 1; rdy = 1;
    step("zero_wait", 1, C_REQ);
    chk("zw_cnt", 32'(cnt), 3);

    mop = 0; ld = 1; rd = 5; rs1 = 5; u1 = 1; mis = 1;
    step("mis", 1, C_MIS);
    chk("mis_cnt", 32'(cnt), 3);
    mop = 1; rdy = 0;
    step("mis_fz", 1, C_FZ);
    clr_in();
    step("mis_rel", 1, C_NONE);

    do_reset();
    mop = 1; rdy = 0;
    for (int i = 0; i < TO; i++) begin
      step("to_wait", 1, C_FZ);
      chk("to_noerr", 32'(err), 0);
    end
    step("to_last", 1, C_FZ);
    chk("to_err", 32'(err), 1);
    for (int i = 0; i < 10; i++) step("err_fz", 1, C_EFZ);
    rdy = 1;
    step("err_abs", 1, C_EFZ);
    chk("sat_cnt", 32'(cnt), CMAX);
    chk("err_hold", 32'(err), 1);
    mid_reset("err_arst");

    mop = 1; rdy = 0;
    step("mw0", 1, C_FZ);
    step("mw1", 1, C_FZ);
    mid_reset("mw_arst");
    step("mw_idle", 1, C_NONE);
    mop = 1; rdy = 1;
    step("mw_after", 1, C_REQ);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      rd  = AW'($urandom_range(0, 7));
      rs1 = AW'($urandom_range(0, 7));
      rs2 = AW'($urandom_range(0, 7));
      ld  = $urandom_range(0, 1) == 1;
      u1  = $urandom_range(0, 3) != 0;
      u2  = $urandom_range(0, 1) == 1;
      mis = $urandom_range(0, 9) == 0;
      mop = $urandom_range(0, 2) == 0;
      rdy = $urandom_range(0, 3) != 0;
      step("rnd", 0, C_NONE);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
